multicycle_control_fsm: RTL and testbench

Multi-cycle control sequencer for the MIPS-subset CPU. It replaces the single-cycle combinational control decode. It sits downstream of the instruction register / instruction-field parser, taking Opcode and the ALU Zero flag. It drives every datapath enable and mux select, one phase per clock.
- Each instruction is split into IF / ID / EXE / MEM / WB phases, so PC, register file and data memory are each written at most once per instruction, in a defined cycle.
- It also keeps a retired-instruction counter for bench checking.

---
 rtl/multicycle_control_fsm.sv | 198 +++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer for the MIPS-subset CPU: walks each instruction
// through IF/ID/EXE/MEM/WB, drives every datapath enable/select and counts retirements.
module multicycle_control_fsm #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 CLK,
   input  logic                 Reset,
   input  logic [5:0]           Opcode,
   input  logic                 Zero,
   output logic                 IRWre,
   output logic                 PCWre,
   output logic                 PCSrc,
   output logic                 RegWre,
   output logic                 RegOut,
   output logic                 ALUSrcB,
   output logic [2:0]           ALUOp,
   output logic                 ExtSel,
   output logic                 DataMemRW,
   output logic                 ALUM2Reg,
   output logic                 Halted,
   output logic [2:0]           state,
   output logic [CNT_WIDTH-1:0] retired
);

   typedef enum logic [2:0] {
      S_IF   = 3'b000,
      S_ID   = 3'b001,
      S_EXE  = 3'b010,
      S_MEM  = 3'b011,
      S_WB   = 3'b100,
      S_HALT = 3'b111
   } state_t;

   localparam logic [5:0] OP_ADD  = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b000001;
   localparam logic [5:0] OP_SUB  = 6'b000010;
   localparam logic [5:0] OP_ORI  = 6'b010000;
   localparam logic [5:0] OP_AND  = 6'b010001;
   localparam logic [5:0] OP_OR   = 6'b010010;
   localparam logic [5:0] OP_MOVE = 6'b100000;
   localparam logic [5:0] OP_SW   = 6'b100110;
   localparam logic [5:0] OP_LW   = 6'b100111;
   localparam logic [5:0] OP_BEQ  = 6'b110000;
   localparam logic [5:0] OP_HALT = 6'b111111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_AND = 3'b100;

   state_t                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   retired_q, retired_d;

   logic op_add, op_addi, op_sub, op_ori, op_and, op_or, op_move;
   logic op_sw, op_lw, op_beq, op_halt;
   logic op_rtype, op_legal;
   logic [2:0] dec_alu_op;
   logic dec_alusrcb, dec_extsel;

   logic irwre_c, pcwre_c, pcsrc_c, regwre_c, regout_c, alusrcb_c;
   logic extsel_c, memrw_c, alum2reg_c, halted_c;
   logic [2:0] aluop_c;

   // Opcode decode; Opcode is stable from ID onward so every phase may use it.
   always_comb begin
      op_add   = (Opcode == OP_ADD);
      op_addi  = (Opcode == OP_ADDI);
      op_sub   = (Opcode == OP_SUB);
      op_ori   = (Opcode == OP_ORI);
      op_and   = (Opcode == OP_AND);
      op_or    = (Opcode == OP_OR);
      op_move  = (Opcode == OP_MOVE);
      op_sw    = (Opcode == OP_SW);
      op_lw    = (Opcode == OP_LW);
      op_beq   = (Opcode == OP_BEQ);
      op_halt  = (Opcode == OP_HALT);
      op_rtype = op_add | op_sub | op_and | op_or | op_move;
      op_legal = op_rtype | op_addi | op_ori | op_sw | op_lw | op_beq | op_halt;

      dec_alu_op = ALU_ADD;
      if (op_sub | op_beq) begin
         dec_alu_op = ALU_SUB;
      end else if (op_or | op_ori) begin
         dec_alu_op = ALU_OR;
      end else if (op_and) begin
         dec_alu_op = ALU_AND;
      end
      dec_alusrcb = op_addi | op_ori | op_lw | op_sw;
      dec_extsel  = op_addi | op_lw | op_sw | op_beq;
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q   <= S_IF;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IF:    state_d = S_ID;
         S_ID: begin
            if (!op_legal) begin
               state_d = S_IF;
            end else if (op_halt) begin
               state_d = S_HALT;
            end else begin
               state_d = S_EXE;
            end
         end
         S_EXE: begin
            if (op_beq) begin
               state_d = S_IF;
            end else if (op_lw | op_sw) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM:   state_d = op_sw ? S_IF : S_WB;
         S_WB:    state_d = S_IF;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IF;
      endcase
   end

   // Immediate-path selects are decoded from ID and held to the end of the instruction.
   always_comb begin
      irwre_c    = 1'b0;
      pcwre_c    = 1'b0;
      pcsrc_c    = 1'b0;
      regwre_c   = 1'b0;
      regout_c   = 1'b0;
      alusrcb_c  = 1'b0;
      aluop_c    = ALU_ADD;
      extsel_c   = 1'b0;
      memrw_c    = 1'b0;
      alum2reg_c = 1'b0;
      halted_c   = 1'b0;
      case (state_q)
         S_IF: irwre_c = 1'b1;
         S_ID: begin
            alusrcb_c = dec_alusrcb;
            extsel_c  = dec_extsel;
            pcwre_c   = ~op_legal;
         end
         S_EXE: begin
            alusrcb_c = dec_alusrcb;
            extsel_c  = dec_extsel;
            aluop_c   = dec_alu_op;
            if (op_beq) begin
               pcwre_c = 1'b1;
               pcsrc_c = Zero;
            end
         end
         S_MEM: begin
            alusrcb_c = dec_alusrcb;
            extsel_c  = dec_extsel;
            aluop_c   = dec_alu_op;
            memrw_c   = op_sw;
            pcwre_c   = op_sw;
         end
         S_WB: begin
            alusrcb_c  = dec_alusrcb;
            extsel_c   = dec_extsel;
            aluop_c    = dec_alu_op;
            regwre_c   = 1'b1;
            pcwre_c    = 1'b1;
            regout_c   = op_rtype;
            alum2reg_c = op_lw;
         end
         S_HALT:  halted_c = 1'b1;
         default: ;
      endcase
   end

   // Reset masks every output immediately so an in-flight instruction cannot commit.
   assign IRWre     = irwre_c    & ~Reset;
   assign PCWre     = pcwre_c    & ~Reset;
   assign PCSrc     = pcsrc_c    & ~Reset;
   assign RegWre    = regwre_c   & ~Reset;
   assign RegOut    = regout_c   & ~Reset;
   assign ALUSrcB   = alusrcb_c  & ~Reset;
   assign ALUOp     = Reset ? 3'b000 : aluop_c;
   assign ExtSel    = extsel_c   & ~Reset;
   assign DataMemRW = memrw_c    & ~Reset;
   assign ALUM2Reg  = alum2reg_c & ~Reset;
   assign Halted    = halted_c   & ~Reset;
   assign state     = Reset ? S_IF : state_q;
   assign retired   = Reset ? '0 : retired_q;

   assign retired_d = retired_q + {{(CNT_WIDTH-1){1'b0}}, PCWre};

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm: a phase-level instruction model
// pushes per-cycle expected output vectors, a negedge monitor pops and compares.
module tb_multicycle_control_fsm;

   localparam int CW = 4;
   localparam int RW = 16 + CW;

   localparam int PH_IF = 0, PH_ID = 1, PH_EXE = 2, PH_MEM = 3, PH_WB = 4, PH_HALT = 5;

   localparam logic [5:0] ADD = 6'b000000, ADDI = 6'b000001, SUB = 6'b000010, ORI = 6'b010000;
   localparam logic [5:0] AND_ = 6'b010001, OR_ = 6'b010010, MOVE = 6'b100000, SW = 6'b100110;
   localparam logic [5:0] LW = 6'b100111, BEQ = 6'b110000, HALT = 6'b111111, ILL = 6'b101010;

   logic          CLK = 1'b0;
   logic          Reset = 1'b1;
   logic [5:0]    Opcode = 6'b0;
   logic          Zero = 1'b0;
   logic          IRWre, PCWre, PCSrc, RegWre, RegOut, ALUSrcB, ExtSel, DataMemRW, ALUM2Reg, Halted;
   logic [2:0]    ALUOp, state;
   logic [CW-1:0] retired;

   logic [RW-1:0] exp_q[$];
   logic [RW-1:0] mon_exp, mon_act;
   int            n_cmp = 0;
   int            n_bad = 0;
   int            ret_model = 0;
   logic [5:0]    legal_ops[10] = '{ADD, ADDI, SUB, ORI, AND_, OR_, MOVE, SW, LW, BEQ};

   always #5 CLK = ~CLK;

   multicycle_control_fsm #(.CNT_WIDTH(CW)) dut (
      .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Zero(Zero),
      .IRWre(IRWre), .PCWre(PCWre), .PCSrc(PCSrc), .RegWre(RegWre), .RegOut(RegOut),
      .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtSel(ExtSel), .DataMemRW(DataMemRW),
      .ALUM2Reg(ALUM2Reg), .Halted(Halted), .state(state), .retired(retired)
   );

   function automatic bit is_r(input logic [5:0] op);
      return op inside {ADD, SUB, AND_, OR_, MOVE};
   endfunction

   // Cycles from IF to retirement for each instruction class.
   function automatic int latency(input logic [5:0] op);
      if (is_r(op) || op == ADDI || op == ORI) return 4;
      if (op == BEQ) return 3;
      if (op == SW) return 4;
      if (op == LW) return 5;
      return 2;
   endfunction

   function automatic int phase_at(input logic [5:0] op, input int k);
      if (k == 0) return PH_IF;
      if (k == 1) return PH_ID;
      if (op == HALT) return PH_HALT;
      if (k == 2) return PH_EXE;
      if (k == 3) return (op == LW || op == SW) ? PH_MEM : PH_WB;
      return PH_WB;
   endfunction

   function automatic logic [2:0] alu_of(input logic [5:0] op);
      if (op == SUB || op == BEQ) return 3'b001;
      if (op == OR_ || op == ORI) return 3'b011;
      if (op == AND_) return 3'b100;
      return 3'b000;
   endfunction

   function automatic logic [RW-1:0] expect_rec(input logic [5:0] op, input logic z, input int k, input int ret);
      int ph;
      logic [2:0] st, aop;
      logic irw, pcw, pcs, rw, ro, asb, ext, mrw, m2r, hlt, dec;
      logic [CW-1:0] r;
      ph = phase_at(op, k);
      case (ph)
         PH_IF:   st = 3'b000;
         PH_ID:   st = 3'b001;
         PH_EXE:  st = 3'b010;
         PH_MEM:  st = 3'b011;
         PH_WB:   st = 3'b100;
         default: st = 3'b111;
      endcase
      dec = (ph >= PH_ID && ph <= PH_WB);
      irw = (ph == PH_IF);
      pcw = (op != HALT) && (k == latency(op) - 1);
      pcs = (op == BEQ) && (ph == PH_EXE) && z;
      rw  = (ph == PH_WB);
      ro  = rw && is_r(op);
      asb = dec && (op inside {ADDI, ORI, LW, SW});
      ext = dec && (op inside {ADDI, LW, SW, BEQ});
      aop = (ph >= PH_EXE && ph <= PH_WB) ? alu_of(op) : 3'b000;
      mrw = (ph == PH_MEM) && (op == SW);
      m2r = (ph == PH_WB) && (op == LW);
      hlt = (ph == PH_HALT);
      r   = CW'(ret % (1 << CW));
      return {st, irw, pcw, pcs, rw, ro, asb, aop, ext, mrw, m2r, hlt, r};
   endfunction

   task automatic do_reset(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge CLK); #1;
         Reset  = 1'b1;
         Opcode = 6'($urandom_range(0, 63));
         Zero   = 1'($urandom_range(0, 1));
         exp_q.push_back('0);
      end
      ret_model = 0;
   endtask

   task automatic run_instr(input logic [5:0] op, input logic zero_exe, input int abort_at);
      int n;
      n = (op == HALT) ? 22 : latency(op);
      for (int k = 0; k < n; k++) begin
         if (k == abort_at) begin
            do_reset(1);
            return;
         end
         @(posedge CLK); #1;
         Reset  = 1'b0;
         Opcode = (k == 0) ? 6'($urandom_range(0, 63)) : op;
         Zero   = (op == BEQ && phase_at(op, k) == PH_EXE) ? zero_exe : 1'($urandom_range(0, 1));
         exp_q.push_back(expect_rec(op, Zero, k, ret_model));
         if (op != HALT && k == n - 1) ret_model++;
      end
   endtask

   initial begin
      forever begin
         @(negedge CLK);
         if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = {state, IRWre, PCWre, PCSrc, RegWre, RegOut, ALUSrcB, ALUOp,
                       ExtSel, DataMemRW, ALUM2Reg, Halted, retired};
            n_cmp++;
            if (mon_act !== mon_exp) begin
               n_bad++;
               $display("FAIL out_vec t=%0t got=%h exp=%h (state,IRWre,PCWre,PCSrc,RegWre,RegOut,ALUSrcB,ALUOp,ExtSel,DataMemRW,ALUM2Reg,Halted,retired)",
                        $time, mon_act, mon_exp);
            end
         end
      end
   end

   initial begin
      logic [5:0] op;
      int         ab;
      do_reset(2);
      run_instr(ADD, 1'b0, -1);
      run_instr(LW, 1'b0, -1);
      run_instr(SW, 1'b0, -1);
      run_instr(BEQ, 1'b1, -1);
      run_instr(BEQ, 1'b0, -1);
      run_instr(ILL, 1'b0, -1);
      run_instr(ADDI, 1'b0, 3);
      run_instr(ORI, 1'b0, -1);
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 3) != 0) begin
            op = legal_ops[$urandom_range(0, 9)];
         end else begin
            op = 6'($urandom_range(0, 63));
            if (op == HALT) op = ILL;
         end
         ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, latency(op) - 1)) : -1;
         run_instr(op, 1'($urandom_range(0, 1)), ab);
      end
      run_instr(HALT, 1'b0, -1);
      do_reset(1);
      run_instr(MOVE, 1'b0, -1);
      run_instr(AND_, 1'b0, -1);
      @(posedge CLK);
      repeat (2) @(negedge CLK);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
